// File: rtl/aes_decrypt_iter128.sv
// rtl/aes_decrypt_iter128.sv - iterative AES-128 inverse cipher, one round per clock
// Round keys: forward expansion to rk10, then the schedule is unwound backwards per round.

module aes_decrypt_iter128 #(
    parameter int KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         ready,
    input  logic [127:0] Indata,
    input  logic [127:0] Key128,
    output logic [127:0] out128,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_KEYEXP,
        S_ROUND
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [127:0]   data_reg;
    logic [127:0]   key_reg;
    logic [3:0]     round_cnt;
    logic           cache_valid;
    logic [127:0]   cache_key;
    logic [127:0]   cache_rk10;
    logic           cache_hit;

    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    f_in;
    logic [31:0]    f_out;
    logic [3:0]     rc_idx;
    logic [127:0]   key_fwd;
    logic [127:0]   key_inv;
    logic [127:0]   rnd_t;
    logic [127:0]   rnd_mix;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // a^254 = a^-1 in GF(2^8); 0 stays 0 without a special case
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] acc;
        p   = gf_mul(a, a);
        acc = p;
        for (int i = 0; i < 6; i++) begin
            p   = gf_mul(p, p);
            acc = gf_mul(acc, p);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Multiply by one of the InvMixColumns constants (9, b, d, e) via xtime chain
    function automatic logic [7:0] gf_mulc(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? a : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
               (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] b0, b1, b2, b3;
        b0 = col[31:24];
        b1 = col[23:16];
        b2 = col[15:8];
        b3 = col[7:0];
        return {gf_mulc(b0, 4'he) ^ gf_mulc(b1, 4'hb) ^ gf_mulc(b2, 4'hd) ^ gf_mulc(b3, 4'h9),
                gf_mulc(b0, 4'h9) ^ gf_mulc(b1, 4'he) ^ gf_mulc(b2, 4'hb) ^ gf_mulc(b3, 4'hd),
                gf_mulc(b0, 4'hd) ^ gf_mulc(b1, 4'h9) ^ gf_mulc(b2, 4'he) ^ gf_mulc(b3, 4'hb),
                gf_mulc(b0, 4'hb) ^ gf_mulc(b1, 4'hd) ^ gf_mulc(b2, 4'h9) ^ gf_mulc(b3, 4'he)};
    endfunction

    // Byte 4c+r sits at row r, column c; row r is rotated right by r columns
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] d);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = inv_sbox(d[127-8*(4*((c+4-r)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] d);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = inv_mix_col(d[127-32*c -: 32]);
        end
        return o;
    endfunction

    assign cache_hit = (KEY_CACHE != 0) && cache_valid && (Key128 == cache_key);

    // One SubWord shared by both directions: forward uses w3, backward uses the recovered w3^w2
    always_comb begin
        w0      = key_reg[127:96];
        w1      = key_reg[95:64];
        w2      = key_reg[63:32];
        w3      = key_reg[31:0];
        f_in    = (state == S_ROUND) ? (w3 ^ w2) : w3;
        rc_idx  = (state == S_ROUND) ? (round_cnt + 4'd1) : round_cnt;
        f_out   = sub_rot_word(f_in) ^ {rcon(rc_idx), 24'h000000};
        key_fwd = {w0 ^ f_out,
                   w1 ^ w0 ^ f_out,
                   w2 ^ w1 ^ w0 ^ f_out,
                   w3 ^ w2 ^ w1 ^ w0 ^ f_out};
        key_inv = {w0 ^ f_out, w1 ^ w0, w2 ^ w1, w3 ^ w2};
        rnd_t   = inv_shift_sub(data_reg) ^ key_inv;
        rnd_mix = inv_mix(rnd_t);
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_next = cache_hit ? S_ROUND : S_KEYEXP;
            end
            S_KEYEXP: begin
                if (round_cnt == 4'd10) state_next = S_ROUND;
            end
            S_ROUND: begin
                if (round_cnt == 4'd0) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg    <= '0;
            key_reg     <= '0;
            round_cnt   <= 4'd0;
            out128      <= '0;
            done        <= 1'b0;
            cache_valid <= 1'b0;
            cache_key   <= '0;
            cache_rk10  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cache_hit) begin
                            data_reg  <= Indata ^ cache_rk10;
                            key_reg   <= cache_rk10;
                            round_cnt <= 4'd9;
                        end else begin
                            data_reg    <= Indata;
                            key_reg     <= Key128;
                            round_cnt   <= 4'd1;
                            cache_key   <= Key128;
                            cache_valid <= 1'b0;
                        end
                    end
                end
                S_KEYEXP: begin
                    key_reg <= key_fwd;
                    if (round_cnt == 4'd10) begin
                        data_reg    <= data_reg ^ key_fwd;
                        cache_rk10  <= key_fwd;
                        cache_valid <= 1'b1;
                        round_cnt   <= 4'd9;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                S_ROUND: begin
                    if (round_cnt != 4'd0) begin
                        data_reg  <= rnd_mix;
                        key_reg   <= key_inv;
                        round_cnt <= round_cnt - 4'd1;
                    end else begin
                        out128 <= rnd_t;
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iter128.sv
// tb/tb_aes_decrypt_iter128.sv - directed and random checks of aes_decrypt_iter128 against a FIPS-197 model
// The model runs the textbook cipher on byte tables built by brute-force GF inversion.

module tb_aes_decrypt_iter128;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] Indata;
    logic [127:0] Key128;
    logic         ready, done, ready0, done0;
    logic [127:0] out128, out0;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    always #5 clk = ~clk;

    aes_decrypt_iter128 #(.KEY_CACHE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .Indata(Indata), .Key128(Key128), .out128(out128), .done(done)
    );

    aes_decrypt_iter128 #(.KEY_CACHE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .ready(ready0),
        .Indata(Indata), .Key128(Key128), .out128(out0), .done(done0)
    );

    logic [7:0] sbox_t  [256];
    logic [7:0] isbox_t [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_xtime(input logic [7:0] a);
        logic [7:0] r;
        r = a << 1;
        if (a[7]) r = r ^ 8'h1b;
        return r;
    endfunction

    function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        while (y != 8'h00) begin
            if (y[0]) p = p ^ x;
            x = m_xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] m_affine(input logic [7:0] x);
        logic [7:0] b;
        logic [7:0] c;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            b[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8] ^ c[i];
        return b;
    endfunction

    function automatic logic [127:0] m_rk(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
                rc = m_xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] m_sub(input logic [127:0] x, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? isbox_t[x[127-8*i -: 8]] : sbox_t[x[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] m_shift(input logic [127:0] x, input bit inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = x[127-8*(4*src+r) -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] m_mix(input logic [127:0] x, input bit inv);
        logic [127:0] o;
        logic [7:0]   cf [4];
        logic [7:0]   acc;
        if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
        else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ m_gmul(cf[(j + 4 - r) % 4], x[127-8*(4*c+j) -: 8]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] m_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s;
        s = pt ^ m_rk(key, 0);
        for (int rd = 1; rd < 10; rd++)
            s = m_mix(m_shift(m_sub(s, 0), 0), 0) ^ m_rk(key, rd);
        return m_shift(m_sub(s, 0), 0) ^ m_rk(key, 10);
    endfunction

    function automatic logic [127:0] m_dec(input logic [127:0] ct, input logic [127:0] key);
        logic [127:0] s;
        s = ct ^ m_rk(key, 10);
        for (int rd = 9; rd >= 1; rd--)
            s = m_mix(m_sub(m_shift(s, 1), 1) ^ m_rk(key, rd), 1);
        return m_sub(m_shift(s, 1), 1) ^ m_rk(key, 0);
    endfunction

    // Transaction-level model of the cached instance: busy for 10 or 20 edges, then result
    int           m_busy = 0;
    bit           m_on   = 0;
    bit           m_done = 0;
    bit           m_cv   = 0;
    logic [127:0] m_ck   = '0;
    logic [127:0] m_res  = '0;
    logic [127:0] m_out  = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_on = 1; m_busy = 0; m_done = 0; m_out = '0; m_cv = 0;
        end else if (m_on) begin
            m_done = 0;
            if (m_busy == 0) begin
                if (start) begin
                    m_busy = (m_cv && Key128 == m_ck) ? 10 : 20;
                    m_res  = m_dec(Indata, Key128);
                    m_ck   = Key128;
                    m_cv   = 0;
                end
            end else begin
                m_busy--;
                if (m_busy == 0) begin
                    m_done = 1; m_out = m_res; m_cv = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("ready", 128'(ready), 128'(m_busy == 0));
            check("done", 128'(done), 128'(m_done));
            check("out128", out128, m_out);
        end
    end

    task automatic run_block(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] pt,
                             input int lat, input bit chk_key, input logic [127:0] exp_key,
                             input bit perturb);
        int n, n_done, n_done0;
        bit got, got0;
        @(negedge clk);
        Indata = ct; Key128 = key; start = 1'b1;
        @(negedge clk);
        start = 1'b0; Indata = ~ct; Key128 = ~key;
        n = 0; got = 0; got0 = 0; n_done = 999; n_done0 = 999;
        while (n < 40 && !(got && got0)) begin
            if (perturb && (n == 2 || n == 14)) begin
                start  = 1'b1;
                Indata = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
            if (chk_key && n == 10) check("key_reg_rk10", dut.key_reg, exp_key);
            if (!got && done) begin
                got = 1; n_done = n;
                check("plaintext", out128, pt);
            end
            if (!got0 && done0) begin
                got0 = 1; n_done0 = n;
                check("plaintext_nocache", out0, pt);
            end
        end
        start = 1'b0;
        check("latency", 128'(n_done), 128'(lat));
        check("latency_nocache", 128'(n_done0), 128'(20));
    endtask

    initial begin
        logic [7:0]   inv;
        logic [127:0] k, p;
        bit           saw_done;

        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (m_gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_t[a] = m_affine(inv);
        end
        for (int a = 0; a < 256; a++) isbox_t[sbox_t[a]] = 8'(a);

        check("model_sbox00", 128'(sbox_t[8'h00]), 128'h63);
        check("model_sbox53", 128'(sbox_t[8'h53]), 128'hed);
        check("model_enc_c1", m_enc(C1_PT, C1_KEY), C1_CT);
        check("model_dec_c1", m_dec(C1_CT, C1_KEY), C1_PT);
        check("model_enc_b", m_enc(B_PT, B_KEY), B_CT);
        check("model_rk10_b", m_rk(B_KEY, 10), B_RK10);

        rst = 1'b1; start = 1'b0; Indata = '0; Key128 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_ready", 128'(ready), 128'(1));
        check("reset_done", 128'(done), 128'(0));
        check("reset_out128", out128, 128'h0);
        check("reset_ready_nocache", 128'(ready0), 128'(1));

        run_block(C1_CT, C1_KEY, C1_PT, 20, 0, '0, 0);
        run_block(B_CT, B_KEY, B_PT, 20, 1, B_RK10, 0);
        run_block(B_CT, B_KEY, B_PT, 10, 0, '0, 0);

        @(negedge clk);
        Indata = C1_CT; Key128 = C1_KEY; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 128'(ready), 128'(1));
        check("midrst_out128", out128, 128'h0);
        check("midrst_done", 128'(done), 128'(0));
        saw_done = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || done0) saw_done = 1;
        end
        check("midrst_no_done", 128'(saw_done), 128'(0));
        run_block(B_CT, B_KEY, B_PT, 20, 0, '0, 0);

        run_block(C1_CT, C1_KEY, C1_PT, 20, 0, '0, 1);
        repeat (5) @(negedge clk);
        check("hold_out128", out128, C1_PT);

        @(negedge clk);
        Indata = B_CT; Key128 = B_KEY; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        check("start_rst_ready", 128'(ready), 128'(1));
        check("start_rst_out128", out128, 128'h0);
        @(negedge clk);
        check("start_rst_idle", 128'(ready), 128'(1));

        for (int i = 0; i < 1000; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            run_block(m_enc(p, k), k, p, 20, 0, '0, 0);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
